// File: rtl/cnn_dot_pkg.sv
// Shared widths, saturation limits and sequencer states for the conv dot-product engine.
package cnn_dot_pkg;
  localparam int DIN0_W = 14;
  localparam int DIN1_W = 9;
  localparam int PROD_W = DIN0_W + DIN1_W;
  localparam int ACC_W  = 32;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, RUN, DRAIN1, DRAIN2, DONE} state_t;
endpackage

// File: rtl/cnn_dot_seq_if.sv
// Control handshake plus feature/weight buffer ports of the dot-product sequencer.
interface cnn_dot_seq_if #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 8
);
  logic                                  ap_start;
  logic                                  ap_done;
  logic                                  ap_idle;
  logic                                  ap_ready;
  logic [ADDR_W:0]                       len;
  logic signed [ACC_W-1:0]               bias;
  logic signed [ACC_W-1:0]               ap_return;
  logic                                  ovf;
  logic [ADDR_W-1:0]                     x_address0;
  logic                                  x_ce0;
  logic signed [cnn_dot_pkg::DIN0_W-1:0] x_q0;
  logic [ADDR_W-1:0]                     w_address0;
  logic                                  w_ce0;
  logic signed [cnn_dot_pkg::DIN1_W-1:0] w_q0;

  modport master (
    output ap_start, len, bias, x_q0, w_q0,
    input  ap_done, ap_idle, ap_ready, ap_return, ovf,
           x_address0, x_ce0, w_address0, w_ce0
  );

  modport slave (
    input  ap_start, len, bias, x_q0, w_q0,
    output ap_done, ap_idle, ap_ready, ap_return, ovf,
           x_address0, x_ce0, w_address0, w_ce0
  );
endinterface

// File: rtl/cnn_dot_mul_14s_9s.sv
// Registered 14s x 9s multiplier, one-cycle latency, maps onto a single DSP slice.
module cnn_dot_mul_14s_9s
  import cnn_dot_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DIN0_W-1:0] a,
  input  logic signed [DIN1_W-1:0] b,
  input  logic                     ce,
  output logic signed [PROD_W-1:0] p
);
  always_ff @(posedge clk) begin
    if (rst)
      p <= '0;
    else if (ce)
      p <= PROD_W'(a) * PROD_W'(b);
  end
endmodule

// File: rtl/cnn_dot_seq.sv
// Dot-product sequencer: streams len operand pairs from two buffers through one
// multiplier into a saturating accumulator seeded with bias.
module cnn_dot_seq #(
  parameter int ACC_W  = cnn_dot_pkg::ACC_W,
  parameter int ADDR_W = 8
) (
  input logic          ap_clk,
  input logic          ap_rst,
  cnn_dot_seq_if.slave bus
);
  import cnn_dot_pkg::*;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ADDR_W:0]         LEN_MAX = (ADDR_W+1)'(1) << ADDR_W;

  state_t                   state;
  logic [ADDR_W:0]          len_r;
  logic [ADDR_W:0]          len_in;
  logic [ADDR_W-1:0]        idx;
  logic                     ce;
  logic                     vld_p0;
  logic                     vld_p1;
  logic signed [PROD_W-1:0] prod_p1;
  logic signed [ACC_W:0]    sum_p1;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic                     ovf_run;
  logic                     ovf_nxt;

  // One extra bit of headroom: overflow shows up as the top two bits disagreeing.
  function automatic logic sat_hit(input logic signed [ACC_W:0] s);
    return s[ACC_W] ^ s[ACC_W-1];
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
    if (sat_hit(s))
      return s[ACC_W] ? SAT_MIN : SAT_MAX;
    return s[ACC_W-1:0];
  endfunction

  assign len_in         = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
  assign bus.x_address0 = idx;
  assign bus.w_address0 = idx;
  assign bus.x_ce0      = ce;
  assign bus.w_ce0      = ce;

  // Stage p0 -> p1: buffer data returned this cycle is captured as the product.
  cnn_dot_mul_14s_9s u_mul (
    .clk (ap_clk),
    .rst (ap_rst),
    .a   (bus.x_q0),
    .b   (bus.w_q0),
    .ce  (vld_p0),
    .p   (prod_p1)
  );

  // Stage p1 -> acc: sign-extended product added, clamped to the accumulator range.
  assign sum_p1 = (ACC_W+1)'(acc) + (ACC_W+1)'(prod_p1);

  always_comb begin
    acc_nxt = acc;
    ovf_nxt = ovf_run;
    if (state == IDLE && bus.ap_start) begin
      acc_nxt = bus.bias;
      ovf_nxt = 1'b0;
    end else if (vld_p1) begin
      acc_nxt = sat_acc(sum_p1);
      ovf_nxt = ovf_run | sat_hit(sum_p1);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state         <= IDLE;
      bus.ap_idle   <= 1'b1;
      bus.ap_done   <= 1'b0;
      bus.ap_ready  <= 1'b0;
      bus.ap_return <= '0;
      bus.ovf       <= 1'b0;
      ce            <= 1'b0;
      idx           <= '0;
      len_r         <= '0;
      vld_p0        <= 1'b0;
      vld_p1        <= 1'b0;
      acc           <= '0;
      ovf_run       <= 1'b0;
    end else begin
      acc          <= acc_nxt;
      ovf_run      <= ovf_nxt;
      vld_p0       <= ce;
      vld_p1       <= vld_p0;
      bus.ap_done  <= 1'b0;
      bus.ap_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ap_start) begin
            len_r       <= len_in;
            idx         <= '0;
            bus.ap_idle <= 1'b0;
            if (len_in != '0) begin
              state <= RUN;
              ce    <= 1'b1;
            end else begin
              state         <= DONE;
              bus.ap_done   <= 1'b1;
              bus.ap_ready  <= 1'b1;
              bus.ap_return <= acc_nxt;
              bus.ovf       <= ovf_nxt;
            end
          end
        end
        RUN: begin
          if ({1'b0, idx} == len_r - 1'b1) begin
            ce    <= 1'b0;
            state <= DRAIN1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DRAIN1: state <= DRAIN2;
        DRAIN2: begin
          state         <= DONE;
          bus.ap_done   <= 1'b1;
          bus.ap_ready  <= 1'b1;
          bus.ap_return <= acc_nxt;
          bus.ovf       <= ovf_nxt;
        end
        DONE: begin
          state       <= IDLE;
          bus.ap_idle <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          bus.ap_idle <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_dot_seq.sv
// Directed bench for cnn_dot_seq: table of short runs plus hand-built multi-cycle cases.
module tb_cnn_dot_seq;
  localparam int ACC_W  = 24;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cnn_dot_seq_if #(.ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus ();
  cnn_dot_seq #(.ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (.ap_clk(clk), .ap_rst(rst), .bus(bus));

  logic signed [13:0] xmem [256];
  logic signed [8:0]  wmem [256];

  always @(posedge clk) begin
    if (bus.x_ce0) bus.x_q0 <= xmem[bus.x_address0];
    if (bus.w_ce0) bus.w_q0 <= wmem[bus.w_address0];
  end

  typedef struct {
    string name;
    int    len;
    int    bias;
    int    x [4];
    int    w [4];
    int    ret;
    int    ovf;
    int    done;
  } vec_t;

  vec_t vt [6];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic fill(input int xv, input int wv);
    for (int i = 0; i < 256; i++) begin
      xmem[i] = 14'(xv);
      wmem[i] = 9'(wv);
    end
  endtask

  task automatic run_job(input string name, input int n, input int b, input int exp_ret,
                         input int exp_ovf, input int exp_done, input bit disturb);
    int done_cyc = -1;
    int ce_cnt   = 0;
    int bad      = 0;
    int idle_cnt = 0;
    int late_ce  = 0;
    int exp_ce   = (n > 256) ? 256 : n;
    @(negedge clk);
    bus.ap_start = 1'b1;
    bus.len      = 9'(n);
    bus.bias     = 24'(b);
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      bus.ap_start = disturb && (c == 2 || c == 3);
      if (disturb && c == 2) begin
        bus.len  = 9'd1;
        bus.bias = 24'(999);
      end
      if (bus.x_ce0 || bus.w_ce0) begin
        if (!(bus.x_ce0 && bus.w_ce0) || bus.x_address0 != 8'(ce_cnt) ||
            bus.w_address0 != 8'(ce_cnt) || c != ce_cnt + 1)
          bad++;
        ce_cnt++;
      end
      if (bus.ap_idle) idle_cnt++;
      if (bus.ap_done) begin
        done_cyc = c;
        if (!bus.ap_ready) bad++;
        break;
      end
    end
    bus.ap_start = 1'b0;
    chk({name, "_done_cycle"}, done_cyc, exp_done);
    chk({name, "_ap_return"}, bus.ap_return, exp_ret);
    chk({name, "_ovf"}, bus.ovf, exp_ovf);
    chk({name, "_ce_count"}, ce_cnt, exp_ce);
    chk({name, "_ce_addr_errors"}, bad, 0);
    chk({name, "_idle_during_run"}, idle_cnt, 0);
    @(negedge clk);
    chk({name, "_idle_after"}, bus.ap_idle, 1);
    chk({name, "_ret_hold"}, bus.ap_return, exp_ret);
    if (disturb) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (bus.x_ce0 || bus.ap_done || !bus.ap_idle) late_ce++;
      end
      chk({name, "_no_extra_run"}, late_ce, 0);
    end
  endtask

  initial begin
    int d1, d2, r1, r2, idle_cnt, idle_at, dones;
    bus.ap_start = 1'b0;
    bus.len      = '0;
    bus.bias     = '0;
    fill(0, 0);

    vt[0] = '{"basic",    4, 10,       '{1, -2, 3, -4},         '{5, 6, -7, 8},         -50,      0, 7};
    vt[1] = '{"len0",     0, -123,     '{0, 0, 0, 0},           '{0, 0, 0, 0},          -123,     0, 1};
    vt[2] = '{"one",      1, 7,        '{-8192, 0, 0, 0},       '{-256, 0, 0, 0},       2097159,  0, 4};
    vt[3] = '{"sat_low",  3, -8388608, '{1, 1, 1, 0},           '{-1, -1, -1, 0},       -8388608, 1, 6};
    vt[4] = '{"sat_cont", 2, 8388600,  '{1, -3, 0, 0},          '{10, 5, 0, 0},         8388592,  1, 5};
    vt[5] = '{"mixed",    4, 0,        '{8191, -8192, 8191, 0}, '{255, -256, -256, 100}, 2088961, 0, 7};

    repeat (3) @(negedge clk);
    chk("reset_idle", bus.ap_idle, 1);
    chk("reset_done", bus.ap_done, 0);
    chk("reset_ce", bus.x_ce0 | bus.w_ce0, 0);
    chk("reset_ret", bus.ap_return, 0);
    chk("reset_ovf", bus.ovf, 0);
    chk("reset_addr", bus.x_address0, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) begin
        xmem[k] = 14'(vt[i].x[k]);
        wmem[k] = 9'(vt[i].w[k]);
      end
      run_job(vt[i].name, vt[i].len, vt[i].bias, vt[i].ret, vt[i].ovf, vt[i].done, 1'b0);
    end

    for (int k = 0; k < 4; k++) begin
      xmem[k] = 14'(vt[0].x[k]);
      wmem[k] = 9'(vt[0].w[k]);
    end
    run_job("disturb", 4, 10, -50, 0, 7, 1'b1);

    fill(-8192, -256);
    run_job("full_sat", 256, 0, 8388607, 1, 259, 1'b0);
    xmem[0] = 14'sd1;
    wmem[0] = 9'sd1;
    run_job("post_sat", 1, 0, 1, 0, 4, 1'b0);
    fill(1, 1);
    run_job("len_clamp", 300, 5, 261, 0, 259, 1'b0);

    // ap_start held: two runs separated by a single IDLE cycle.
    xmem[0] = 14'sd3;  wmem[0] = 9'sd7;
    xmem[1] = -14'sd5; wmem[1] = 9'sd2;
    d1 = -1; d2 = -1; r1 = 0; r2 = 0; idle_cnt = 0; idle_at = -1;
    @(negedge clk);
    bus.ap_start = 1'b1;
    bus.len      = 9'd2;
    bus.bias     = 24'sd1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 3) bus.bias = 24'sd100;
      if (bus.ap_idle) begin
        idle_cnt++;
        idle_at = c;
      end
      if (bus.ap_done) begin
        if (d1 < 0) begin
          d1 = c;
          r1 = int'(bus.ap_return);
        end else begin
          d2 = c;
          r2 = int'(bus.ap_return);
        end
      end
    end
    bus.ap_start = 1'b0;
    chk("hold_done1_cycle", d1, 5);
    chk("hold_done2_cycle", d2, 11);
    chk("hold_idle_count", idle_cnt, 1);
    chk("hold_idle_cycle", idle_at, 6);
    chk("hold_ret1", r1, 12);
    chk("hold_ret2", r2, 111);
    repeat (2) @(negedge clk);

    // Reset in the third RUN cycle of a len=8 run.
    fill(2, 3);
    @(negedge clk);
    bus.ap_start = 1'b1;
    bus.len      = 9'd8;
    bus.bias     = 24'sd0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.ap_start = 1'b0;
      if (c == 3) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("abort_idle", bus.ap_idle, 1);
    chk("abort_ce", bus.x_ce0 | bus.w_ce0, 0);
    chk("abort_done", bus.ap_done, 0);
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.ap_done || bus.x_ce0) dones++;
    end
    chk("abort_no_done", dones, 0);
    xmem[0] = -14'sd7;
    wmem[0] = 9'sd9;
    run_job("after_abort", 1, 100, 37, 0, 4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cnn_dot_seq.md
Name: cnn_dot_seq

Overview:
- Sequencer that computes one signed dot product (conv-kernel MAC) over `len` operand pairs from two single-port on-chip buffers.
- Pairs are a 14-bit signed feature and a 9-bit signed weight, multiplied on one shared 14s x 9s DSP multiplier.
- Accumulates with saturation on top of a bias.
- Sits between the conv-layer loop controller, which drives ap_ctrl_hs-style start/done, and the feature/weight BRAMs.

Parameters:
- DIN0_W, 14, feature operand width (signed)
- DIN1_W, 9, weight operand width (signed)
- PROD_W, 23, product width = DIN0_W+DIN1_W
- ACC_W, 32, accumulator/result width (signed), must be >= PROD_W
- ADDR_W, 8, buffer address width; max len = 2**ADDR_W

Ports:
- ap_clk in 1 clock, rising edge
- ap_rst in 1 synchronous reset, active-high
- ap_start in 1 start request
- ap_done out 1 one-cycle pulse, result valid
- ap_idle out 1 high while in IDLE
- ap_ready out 1 one-cycle pulse, same cycle as ap_done
- len in ADDR_W+1 number of pairs, sampled at start
- bias in ACC_W signed initial accumulator value, sampled at start
- x_address0 out ADDR_W feature buffer address
- x_ce0 out 1 feature buffer read enable
- x_q0 in DIN0_W feature data, 1-cycle read latency
- w_address0 out ADDR_W weight buffer address
- w_ce0 out 1 weight buffer read enable
- w_q0 in DIN1_W weight data, 1-cycle read latency
- ap_return out ACC_W signed dot-product result
- ovf out 1 saturation occurred during last run (sticky per run)

Behaviour:
- Reset: state=IDLE, ap_idle=1.
  - ap_done, ap_ready, x_ce0, w_ce0, ovf = 0.
  - ap_return, addresses, acc, product register = 0.
  - Reset asserted in any state aborts the run and returns to IDLE next cycle; no ap_done is issued.
- States: IDLE, RUN, DRAIN1, DRAIN2, DONE.
- Cycle 0 is an IDLE cycle with ap_start=1: start is accepted.
  - Latch len and bias; acc<=bias, ovf<=0, idx<=0.
  - Next state is RUN if len>0, else DONE.
- RUN, cycles 1..N:
  - x_ce0=w_ce0=1, x_address0=w_address0=idx; idx increments each cycle.
  - The last RUN cycle has idx=N-1; then go to DRAIN1.
  - ce=0 in every other state.
- Datapath pipeline:
  - q valid in cycle k+1 for an address issued in cycle k.
  - The multiplier registers the product at the end of that cycle.
  - The accumulator adds the sign-extended product one cycle later.
  - A valid bit travels with each stage; acc updates only when it is set.
- DRAIN1 and DRAIN2 each last one cycle, then DONE.
- DONE, cycle N+3 (cycle 1 when len=0):
  - ap_done=ap_ready=1 and ap_return=final acc.
  - Next state IDLE unconditionally.
  - A held ap_start is accepted again at the earliest in the following IDLE cycle.
- ap_start outside IDLE is ignored. len/bias changes after acceptance are ignored.
- ap_return and ovf hold their value from DONE until the next DONE or reset.
- Arithmetic:
  - product = signed(x_q0)*signed(w_q0), exact in PROD_W.
  - sum = acc + sext(product), computed in ACC_W+1.
  - If sum > 2^(ACC_W-1)-1, acc = max and ovf<=1. If sum < -2^(ACC_W-1), acc = min and ovf<=1. Otherwise acc = sum.
  - Once saturated, later terms continue to accumulate from the clamped value.
- len > 2**ADDR_W is illegal; the design clamps it to 2**ADDR_W.

Decomposition:
- Shared package cnn_dot_pkg:
  - width constants DIN0_W/DIN1_W/PROD_W/ACC_W.
  - state enum (IDLE, RUN, DRAIN1, DRAIN2, DONE).
  - ACC_MAX/ACC_MIN constants.
- One sub-module, cnn_dot_mul_14s_9s: registered signed multiplier with ports a, b, ce, p.
  - One-cycle latency, DSP-inferable.
  - It is the only multiplier instance.

Test Plan:
- len=4, bias=10, x={1,-2,3,-4}, w={5,6,-7,8}: ap_return=10+5-12-21-32=-50. ap_done exactly in cycle 7 after acceptance. ce high in cycles 1..4 only, addresses 0..3. ovf=0.
- len=0, bias=-123: ap_done in cycle 1, ap_return=-123, no ce pulses.
- Full-scale saturation: ACC_W=24, len=256, all x=-8192, w=-256, bias=0.
  - Each product is +2097152.
  - ap_return=8388607 (clamped), ovf=1.
  - A following run with len=1, x=1, w=1 gives ap_return=1, ovf=0.
- ap_start held high continuously, len=2: back-to-back runs with exactly one IDLE cycle between DONE and the next RUN. ap_idle=1 only in that cycle. Both results correct.
- ap_rst asserted in the 3rd RUN cycle of a len=8 run: next cycle IDLE, ap_idle=1, ce=0, no ap_done. A subsequent len=1 run returns bias+x*w correctly.
- Change len/bias and ap_start pulses during RUN: result uses the values latched at acceptance, and no extra run starts.
